// File: rtl/sram_mem_ctrl.sv
// Memory-access controller between the ELC-3 core and an asynchronous board SRAM.
// One access per MIO_EN request, fixed wait states, one-cycle R pulse, plus one I/O word.
module sram_mem_ctrl #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF,
  parameter logic [3:0]  ADDR_HI     = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] Addr,
  input  logic [15:0] Data_From_CPU,
  output logic [15:0] Data_To_CPU,
  output logic        R,
  input  logic [15:0] SW,
  output logic [15:0] IO_Out,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned   CW        = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_STATES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          rw_q, rw_d;
  logic [15:0]   dout_q, dout_d;
  logic [15:0]   io_q, io_d;
  logic          r_q, r_d;
  logic [19:0]   sram_addr_q, sram_addr_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          dq_oe_q, dq_oe_d;

  logic          is_io_s;
  logic          access_last_s;
  logic          start_s;

  assign is_io_s       = (Addr == IO_ADDR);
  assign access_last_s = (cnt_q == LAST_WAIT);
  assign start_s       = (state_q == ST_IDLE) && MIO_EN;

  // State register and wait counter
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (MIO_EN) begin
          state_d = is_io_s ? ST_DONE : ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        if (access_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCESS;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, read-data capture and I/O register updates
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    dout_d  = dout_q;
    io_d    = io_q;
    if (start_s) begin
      addr_d  = Addr;
      wdata_d = Data_From_CPU;
      rw_d    = R_W;
      if (is_io_s) begin
        if (R_W) begin
          io_d = Data_From_CPU;
        end else begin
          dout_d = SW;
        end
      end else begin
        io_d = io_q;
      end
    end else if ((state_q == ST_ACCESS) && access_last_s && !rw_q) begin
      dout_d = SRAM_DQ;
    end else begin
      dout_d = dout_q;
    end
  end

  // Output decode from the upcoming state so every strobe leaves a flop
  always_comb begin
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    r_d         = 1'b0;
    sram_addr_d = sram_addr_q;
    case (state_d)
      ST_IDLE: r_d = 1'b0;
      ST_SETUP: begin
        ce_n_d      = 1'b0;
        oe_n_d      = rw_d;
        sram_addr_d = {ADDR_HI, addr_d};
      end
      ST_ACCESS: begin
        ce_n_d      = 1'b0;
        oe_n_d      = rw_d;
        we_n_d      = !rw_d;
        dq_oe_d     = rw_d;
        sram_addr_d = {ADDR_HI, addr_d};
      end
      ST_DONE: r_d = 1'b1;
      default: r_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      rw_q        <= 1'b0;
      dout_q      <= 16'h0000;
      io_q        <= 16'h0000;
      r_q         <= 1'b0;
      sram_addr_q <= 20'h00000;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      dout_q      <= dout_d;
      io_q        <= io_d;
      r_q         <= r_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  // DQ is enabled from the same edge that lowers WE_N, never alongside OE_N
  assign SRAM_DQ     = dq_oe_q ? wdata_q : 16'hzzzz;
  assign Data_To_CPU = dout_q;
  assign IO_Out      = io_q;
  assign R           = r_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_LB_N   = ce_n_q;
  assign SRAM_UB_N   = ce_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: transaction-level reference model checked every cycle,
// directed literal checks, reset abort and randomized requests.
module tb_sram_mem_ctrl;

  localparam int WS = 1;

  logic        clk;
  logic        rst_n;
  logic        mio_en;
  logic        rw;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        r;
  logic [15:0] sw;
  logic [15:0] io_out;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [15:0] sram_mem [16];
  logic [15:0] ref_mem  [16];

  sram_mem_ctrl #(.WAIT_STATES(WS), .IO_ADDR(16'hFFFF), .ADDR_HI(4'h0)) dut (
    .Clk(clk), .Reset_N(rst_n), .MIO_EN(mio_en), .R_W(rw), .Addr(addr),
    .Data_From_CPU(din), .Data_To_CPU(dout), .R(r), .SW(sw), .IO_Out(io_out),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );

  // Asynchronous SRAM device: drives DQ on reads, stores on write-strobe cycles
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[3:0]] : 16'hzzzz;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !ce_n && !we_n) sram_mem[sram_addr[3:0]] = sram_dq;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: an access is a sequence of phases after the request cycle.
  // SRAM: phases 1..1+WS assert CE (OE for reads, WE+DQ for writes from phase 2),
  // phase 2+WS is the R pulse. I/O: phase 1 is the R pulse.
  initial begin
    int          k;
    int          lat;
    bit          m_io, m_rw, act, wr_ph, done;
    logic [15:0] m_addr, m_data, exp_dout, exp_io;
    k = 0; lat = 0; m_io = 1'b0; m_rw = 1'b0; m_addr = 16'h0; m_data = 16'h0;
    exp_dout = 16'h0; exp_io = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k = 0; exp_dout = 16'h0; exp_io = 16'h0;
        chk("rst_r", {31'd0, r}, 32'd0);
        chk("rst_ce_n", {31'd0, ce_n}, 32'd1);
        chk("rst_we_n", {31'd0, we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
        chk("rst_dout", {16'd0, dout}, 32'd0);
        chk("rst_io", {16'd0, io_out}, 32'd0);
        chk("rst_addr", {12'd0, sram_addr}, 32'd0);
      end else begin
        act   = (k >= 1) && (k <= 1 + WS) && !m_io;
        wr_ph = act && m_rw && (k >= 2);
        done  = (k != 0) && (k == lat);
        chk("m_r", {31'd0, r}, {31'd0, done});
        chk("m_ce_n", {31'd0, ce_n}, {31'd0, !act});
        chk("m_lb_ub", {30'd0, lb_n, ub_n}, {30'd0, !act, !act});
        chk("m_oe_n", {31'd0, oe_n}, {31'd0, !(act && !m_rw)});
        chk("m_we_n", {31'd0, we_n}, {31'd0, !wr_ph});
        if (act) chk("m_sram_addr", {12'd0, sram_addr}, {16'd0, m_addr});
        if (wr_ph) chk("m_dq", {16'd0, sram_dq}, {16'd0, m_data});
        chk("m_dout", {16'd0, dout}, {16'd0, exp_dout});
        chk("m_io", {16'd0, io_out}, {16'd0, exp_io});
        if (k == 0) begin
          if (mio_en) begin
            m_addr = addr; m_data = din; m_rw = rw; m_io = (addr == 16'hFFFF);
            lat = m_io ? 1 : 2 + WS;
            k = 1;
            if (m_io && m_rw) exp_io = din;
            else if (m_io) exp_dout = sw;
            else if (m_rw) ref_mem[addr[3:0]] = din;
          end
        end else if (k == lat) begin
          k = 0;
        end else begin
          if ((k == lat - 1) && !m_io && !m_rw) exp_dout = ref_mem[m_addr[3:0]];
          k++;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mio_en = 1'b0;
    end
  endtask

  task automatic request(input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    mio_en = 1'b1; rw = w; addr = a; din = d;
  endtask

  initial begin
    int p0, p1, npulse;
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = 16'h0000;
      ref_mem[i]  = 16'h0000;
    end
    rst_n = 1'b0; mio_en = 1'b0; rw = 1'b0; addr = 16'h0; din = 16'h0; sw = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // SRAM write 0x3000 <- 0xBEEF, with inputs changed mid-access
    request(1'b1, 16'h3000, 16'hBEEF);
    @(negedge clk); chk("wr_c0_ce", {31'd0, ce_n}, 32'd1);
    @(posedge clk); #1; mio_en = 1'b0; addr = 16'h3005; din = 16'h0000;
    @(negedge clk); chk("wr_c1_addr", {12'd0, sram_addr}, 32'h03000);
    chk("wr_c1_we", {31'd0, we_n}, 32'd1);
    @(negedge clk); chk("wr_c2_we", {31'd0, we_n}, 32'd0);
    chk("wr_c2_dq", {16'd0, sram_dq}, 32'h0000BEEF);
    @(negedge clk); chk("wr_c3_r", {31'd0, r}, 32'd1);
    chk("wr_c3_we", {31'd0, we_n}, 32'd1);
    idle(2);

    // SRAM read back 0x3000
    request(1'b0, 16'h3000, 16'h0000);
    @(posedge clk); #1; mio_en = 1'b0;
    @(negedge clk); chk("rd_c1_oe", {31'd0, oe_n}, 32'd0);
    @(negedge clk); chk("rd_c2_oe", {31'd0, oe_n}, 32'd0);
    @(negedge clk); chk("rd_c3_r", {31'd0, r}, 32'd1);
    chk("rd_c3_data", {16'd0, dout}, 32'h0000BEEF);
    idle(2);

    // I/O read of switches
    sw = 16'h0005;
    request(1'b0, 16'hFFFF, 16'h0000);
    @(negedge clk); chk("ior_c0_ce", {31'd0, ce_n}, 32'd1);
    @(posedge clk); #1; mio_en = 1'b0;
    @(negedge clk); chk("ior_c1_r", {31'd0, r}, 32'd1);
    chk("ior_c1_data", {16'd0, dout}, 32'h00000005);
    chk("ior_c1_ce", {31'd0, ce_n}, 32'd1);
    idle(2);

    // I/O write to display register
    request(1'b1, 16'hFFFF, 16'h1234);
    @(posedge clk); #1; mio_en = 1'b0;
    @(negedge clk); chk("iow_c1_r", {31'd0, r}, 32'd1);
    @(negedge clk); chk("iow_c2_io", {16'd0, io_out}, 32'h00001234);
    chk("iow_c2_ce", {31'd0, ce_n}, 32'd1);
    idle(2);

    // MIO_EN held high across back-to-back reads while Addr wanders
    request(1'b0, 16'h3000, 16'h0000);
    p0 = -1; p1 = -1; npulse = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((c == 1) || (c == 2)) chk("hold_addr", {12'd0, sram_addr}, 32'h03000);
      if (r) begin
        if (npulse == 0) p0 = c;
        else if (npulse == 1) p1 = c;
        npulse++;
      end
      @(posedge clk); #1;
      addr = {12'h300, 4'($urandom_range(0, 15))};
    end
    mio_en = 1'b0;
    chk("hold_first_r", p0, 32'd3);
    chk("hold_gap", p1 - p0, 32'd4);
    idle(6);

    // Reset asserted during write ACCESS
    request(1'b1, 16'h3002, 16'hA5A5);
    @(posedge clk); #1; mio_en = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("abort_pre_we", {31'd0, we_n}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we", {31'd0, we_n}, 32'd1);
    chk("abort_ce", {31'd0, ce_n}, 32'd1);
    chk("abort_r", {31'd0, r}, 32'd0);
    @(negedge clk); chk("abort_no_r", {31'd0, r}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Normal traffic after release
    request(1'b1, 16'h3003, 16'h5A5A);
    idle(4);
    request(1'b0, 16'h3003, 16'h0000);
    @(posedge clk); #1; mio_en = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("post_rst_r", {31'd0, r}, 32'd1);
    chk("post_rst_data", {16'd0, dout}, 32'h00005A5A);
    idle(2);

    // Randomized requests, inputs changing every cycle
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      mio_en = ($urandom_range(0, 2) != 0);
      rw     = 1'($urandom_range(0, 1));
      addr   = ($urandom_range(0, 5) == 0) ? 16'hFFFF : {12'h300, 4'($urandom_range(0, 15))};
      din    = 16'($urandom);
      sw     = 16'($urandom);
    end
    idle(10);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
